// File: rtl/keypad_calc_ctrl.sv
// Keypad-to-FP-datapath sequencer: debounces scanner keys into single
// events, builds two decimal operands and handshakes the calculation.
module keypad_calc_ctrl #(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4,
  parameter int DEBOUNCE   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  key_value,
  input  logic         key_valid,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [1:0]   opcode,
  output logic         calc_req,
  input  logic         calc_ack,
  output logic [W-1:0] disp_value,
  output logic         result_show,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
  localparam logic [DW-1:0] DG_MAX = DW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_REQ = 2'd2,
    S_RES = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [1:0]      opc_q, opc_d;
  logic [DW-1:0]   cnt_a_q, cnt_a_d;
  logic [DW-1:0]   cnt_b_q, cnt_b_d;
  logic [CW-1:0]   prs_q, prs_d;
  logic [CW-1:0]   rel_q, rel_d;
  logic            held_q, held_d;
  logic [3:0]      prev_val_q;
  logic            prev_ok_q;

  logic            key_ok;
  logic            same;
  logic            key_evt;
  logic [3:0]      code;
  logic            is_dig, is_op, is_clr, is_eq;

  assign key_ok = key_valid && (key_value <= 16'd15);
  assign same   = key_ok && prev_ok_q
               && (key_value[3:0] == prev_val_q);

  // prs counts consecutive identical legal samples, rel counts released ones
  always_comb begin
    prs_d = '0;
    rel_d = '0;
    if (key_ok) begin
      if (!same)                prs_d = CW'(1);
      else if (prs_q != DB_MAX) prs_d = prs_q + CW'(1);
      else                      prs_d = prs_q;
    end else begin
      if (rel_q != DB_MAX) rel_d = rel_q + CW'(1);
      else                 rel_d = rel_q;
    end
  end

  assign key_evt = (prs_q == DB_MAX) && !held_q;
  // the stored sample is the key that completed the stable run
  assign code    = prev_val_q;

  always_comb begin
    held_d = held_q;
    if (key_evt)              held_d = 1'b1;
    else if (rel_d == DB_MAX) held_d = 1'b0;
  end

  assign is_dig = (code <= 4'd9);
  assign is_op  = (code >= 4'd10) && (code <= 4'd13);
  assign is_clr = (code == 4'd14);
  assign is_eq  = (code == 4'd15);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    opc_d   = opc_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    unique case (state_q)
      S_A: if (key_evt) begin
        unique case (1'b1)
          is_dig: if (cnt_a_q < DG_MAX) begin
            op_a_d  = op_a_q * W'(10) + W'(code);
            cnt_a_d = cnt_a_q + DW'(1);
          end
          is_op: if (cnt_a_q != '0) begin
            opc_d   = code[1:0] - 2'd2;
            op_b_d  = '0;
            cnt_b_d = '0;
            state_d = S_B;
          end
          is_clr: begin
            op_a_d  = '0;
            op_b_d  = '0;
            opc_d   = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
          end
          default: ;
        endcase
      end
      S_B: if (key_evt) begin
        unique case (1'b1)
          is_dig: if (cnt_b_q < DG_MAX) begin
            op_b_d  = op_b_q * W'(10) + W'(code);
            cnt_b_d = cnt_b_q + DW'(1);
          end
          is_op: opc_d = code[1:0] - 2'd2;
          is_eq: if (cnt_b_q != '0) state_d = S_REQ;
          is_clr: begin
            op_a_d  = '0;
            op_b_d  = '0;
            opc_d   = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = S_A;
          end
          default: ;
        endcase
      end
      S_REQ: if (calc_ack) state_d = S_RES;
      S_RES: if (key_evt) begin
        unique case (1'b1)
          is_dig: begin
            op_a_d  = W'(code);
            cnt_a_d = DW'(1);
            op_b_d  = '0;
            cnt_b_d = '0;
            state_d = S_A;
          end
          is_clr: begin
            op_a_d  = '0;
            op_b_d  = '0;
            opc_d   = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = S_A;
          end
          default: ;
        endcase
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opc_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      prs_q      <= '0;
      rel_q      <= '0;
      held_q     <= 1'b0;
      prev_val_q <= '0;
      prev_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opc_q      <= opc_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      prs_q      <= prs_d;
      rel_q      <= rel_d;
      held_q     <= held_d;
      prev_val_q <= key_value[3:0];
      prev_ok_q  <= key_ok;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign opcode      = opc_q;
  assign calc_req    = (state_q == S_REQ);
  assign result_show = (state_q == S_RES);
  assign state_dbg   = state_q;

  always_comb begin
    unique case (state_q)
      S_A:     disp_value = op_a_q;
      S_B:     disp_value = op_b_q;
      S_REQ:   disp_value = op_b_q;
      default: disp_value = '0;
    endcase
  end

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Bench for keypad_calc_ctrl: directed vector table, hand sequences,
// then random key traffic against a sliding-window reference model.
module tb_keypad_calc_ctrl;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_value;
  logic        key_valid;
  logic        calc_ack;
  logic [15:0] op_a, op_b, disp_value;
  logic [1:0]  opcode, state_dbg;
  logic        calc_req, result_show;

  int n_run  = 0;
  int n_fail = 0;
  bit rnd_chk = 0;

  always #5 clk = ~clk;

  keypad_calc_ctrl #(.W(16), .MAX_DIGITS(4), .DEBOUNCE(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_value(key_value), .key_valid(key_valid),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .calc_req(calc_req), .calc_ack(calc_ack),
    .disp_value(disp_value), .result_show(result_show),
    .state_dbg(state_dbg)
  );

  // reference model: calculator state as plain integers
  int m_st, m_a, m_b, m_op, m_ca, m_cb, m_pend;
  bit m_held;
  int win[$];

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0;
    m_ca = 0; m_cb = 0; m_pend = -1;
    m_held = 0;
    win.delete();
  endtask

  task automatic m_clear();
    m_a = 0; m_b = 0; m_op = 0;
    m_ca = 0; m_cb = 0; m_st = 0;
  endtask

  task automatic m_key(input int k);
    case (m_st)
      0: begin
        if (k <= 9) begin
          if (m_ca < 4) begin m_a = m_a * 10 + k; m_ca++; end
        end else if (k <= 13) begin
          if (m_ca > 0) begin
            m_op = k - 10; m_b = 0; m_cb = 0; m_st = 1;
          end
        end else if (k == 14) m_clear();
      end
      1: begin
        if (k <= 9) begin
          if (m_cb < 4) begin m_b = m_b * 10 + k; m_cb++; end
        end else if (k <= 13) m_op = k - 10;
        else if (k == 14) m_clear();
        else if (m_cb > 0) m_st = 2;
      end
      3: begin
        if (k <= 9) begin
          m_a = k; m_ca = 1; m_b = 0; m_cb = 0; m_st = 0;
        end else if (k == 14) m_clear();
      end
      default: ;
    endcase
  endtask

  task automatic model_step(input bit v, input int k, input bit ack);
    int s;
    bit all;
    if (m_st == 2) begin
      if (ack) m_st = 3;
    end else if (m_pend >= 0) m_key(m_pend);
    m_pend = -1;
    s = (v && k <= 15) ? k : -1;
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    if (win.size() == D) begin
      all = 1;
      foreach (win[j]) if (win[j] != win[0]) all = 0;
      if (all && win[0] >= 0 && !m_held) begin
        m_pend = win[0]; m_held = 1;
      end else if (all && win[0] < 0) m_held = 0;
    end
  endtask

  function automatic logic [53:0] pack_exp(
    int st, int a, int b, int op, int disp, bit req, bit show);
    return {st[1:0], a[15:0], b[15:0], op[1:0],
            disp[15:0], req, show};
  endfunction

  function automatic logic [53:0] pack_dut();
    return {state_dbg, op_a, op_b, opcode,
            disp_value, calc_req, result_show};
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] k,
                     input bit ack, input int n);
    int md;
    for (int i = 0; i < n; i++) begin
      key_valid = v; key_value = k; calc_ack = ack;
      @(posedge clk);
      model_step(v, int'(k), ack);
      @(negedge clk);
      if (rnd_chk) begin
        md = (m_st == 0) ? m_a : (m_st == 3) ? 0 : m_b;
        check("rand", 64'(pack_dut()),
              64'(pack_exp(m_st, m_a, m_b, m_op, md,
                           m_st == 2, m_st == 3)));
      end
    end
  endtask

  task automatic press(input logic [15:0] k);
    cyc(1'b1, k, 1'b0, D + 2);
    cyc(1'b0, 16'd0, 1'b0, D + 2);
  endtask

  task automatic ack_seq();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1);
      check("req_hold", 64'(calc_req), 64'd1);
    end
    cyc(1'b0, 16'd0, 1'b1, 1);
    check("req_drop", 64'(calc_req), 64'd0);
    check("show", 64'(result_show), 64'd1);
    cyc(1'b0, 16'd0, 1'b0, 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int key;
    int st, a, b, op, disp;
    bit req, show;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int key, int st, int a, int b,
                     int op, int disp, bit req, bit show);
    vec_t r;
    r.key = key; r.st = st; r.a = a; r.b = b;
    r.op = op; r.disp = disp; r.req = req; r.show = show;
    tbl.push_back(r);
  endtask

  initial begin
    bit v;
    int r, len;
    logic [15:0] k;

    // key 16 is the ack action, not a key press
    add(1,  0, 1,    0, 0, 1,    0, 0);
    add(2,  0, 12,   0, 0, 12,   0, 0);
    add(10, 1, 12,   0, 0, 0,    0, 0);
    add(3,  1, 12,   3, 0, 3,    0, 0);
    add(15, 2, 12,   3, 0, 3,    1, 0);
    add(16, 3, 12,   3, 0, 0,    0, 1);
    add(12, 3, 12,   3, 0, 0,    0, 1);
    add(15, 3, 12,   3, 0, 0,    0, 1);
    add(8,  0, 8,    0, 0, 8,    0, 0);
    add(14, 0, 0,    0, 0, 0,    0, 0);
    add(9,  0, 9,    0, 0, 9,    0, 0);
    add(9,  0, 99,   0, 0, 99,   0, 0);
    add(9,  0, 999,  0, 0, 999,  0, 0);
    add(9,  0, 9999, 0, 0, 9999, 0, 0);
    add(9,  0, 9999, 0, 0, 9999, 0, 0);
    add(15, 0, 9999, 0, 0, 9999, 0, 0);
    add(14, 0, 0,    0, 0, 0,    0, 0);
    add(10, 0, 0,    0, 0, 0,    0, 0);
    add(7,  0, 7,    0, 0, 7,    0, 0);
    add(10, 1, 7,    0, 0, 0,    0, 0);
    add(12, 1, 7,    0, 2, 0,    0, 0);
    add(4,  1, 7,    4, 2, 4,    0, 0);
    add(14, 0, 0,    0, 0, 0,    0, 0);
    add(7,  0, 7,    0, 0, 7,    0, 0);
    add(10, 1, 7,    0, 0, 0,    0, 0);
    add(12, 1, 7,    0, 2, 0,    0, 0);
    add(4,  1, 7,    4, 2, 4,    0, 0);
    add(15, 2, 7,    4, 2, 4,    1, 0);
    add(14, 2, 7,    4, 2, 4,    1, 0);
    add(16, 3, 7,    4, 2, 0,    0, 1);
    add(0,  0, 0,    0, 2, 0,    0, 0);
    add(5,  0, 5,    0, 2, 5,    0, 0);
    add(14, 0, 0,    0, 0, 0,    0, 0);

    key_valid = 1'b0; key_value = '0; calc_ack = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", 64'(pack_dut()),
          64'(pack_exp(0, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].key == 16) ack_seq();
      else press(16'(tbl[i].key));
      check($sformatf("vec%0d", i), 64'(pack_dut()),
            64'(pack_exp(tbl[i].st, tbl[i].a, tbl[i].b,
                         tbl[i].op, tbl[i].disp,
                         tbl[i].req, tbl[i].show)));
    end

    // asynchronous reset in the middle of a request
    press(16'd1); press(16'd10); press(16'd2); press(16'd15);
    check("pre_rst_req", 64'(calc_req), 64'd1);
    #2;
    key_valid = 1'b1; key_value = 16'd3;
    rst_n = 1'b0;
    #1;
    check("async_req", 64'(calc_req), 64'd0);
    check("async_st", 64'(state_dbg), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 16'd3, 1'b0, D);
    check("post_rst_wait", 64'(op_a), 64'd0);
    cyc(1'b1, 16'd3, 1'b0, 1);
    check("post_rst_evt", 64'(op_a), 64'd3);
    cyc(1'b0, 16'd0, 1'b0, D + 2);
    press(16'd14);
    check("clr", 64'(op_a), 64'd0);

    // bouncing contact, then a short clean hold of exactly D cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'd5, 1'b0, 3);
      cyc(1'b0, 16'd5, 1'b0, 3);
    end
    check("bounce_none", 64'(op_a), 64'd0);
    cyc(1'b1, 16'd5, 1'b0, D);
    cyc(1'b0, 16'd0, 1'b0, D + 2);
    check("bounce_one", 64'(op_a), 64'd5);

    // random traffic against the reference model
    do_reset();
    rnd_chk = 1;
    for (int s = 0; s < 400; s++) begin
      v = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 19);
      k = (r < 16) ? 16'(r) : (r < 18) ? 16'(r + 4) : 16'hFFFF;
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++)
        cyc(v, k, ($urandom_range(0, 5) == 0), 1);
    end
    rnd_chk = 0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_calc_ctrl.md
Name: keypad_calc_ctrl

Overview:
- Sequencing controller between the keypad scanner (`value`/`valid` outputs) and the floating-point calculator datapath.
- Debounces key presses into single-cycle key events and accumulates decimal digits into two unsigned binary operands.
- Latches an operator and issues a req/ack handshake to the FP unit when "=" is pressed.
- Provides the current entry value and a result-show flag to the display path.

Parameters:
- W, 16, operand width in bits. Must hold 10^MAX_DIGITS-1.
- MAX_DIGITS, 4, maximum decimal digits per operand. Extra digits are ignored.
- DEBOUNCE, 8, consecutive stable clk cycles required to accept a press or release. Minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_value  in  16  decoded key from scanner. Only 0..15 is legal; any value >15 is treated as no key.
- key_valid  in  1  scanner key-present level; held while the key is down
- op_a  out  W  first operand, binary
- op_b  out  W  second operand, binary
- opcode  out  2  0=add 1=sub 2=mul 3=div
- calc_req  out  1  request to FP datapath
- calc_ack  in  1  datapath acceptance. Sampled only while calc_req=1.
- disp_value  out  W  operand currently being entered
- result_show  out  1  display should show the datapath result
- state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset (async on rst_n=0):
  - All outputs 0; state S_A.
  - Accumulators, digit counts and debounce counters cleared; held flag cleared.
- Key map: 0-9 digit; A add; B sub; C mul; D div; E clear; F equals.
- Debounce:
  - Counter increments each cycle while key_valid=1 and key_value equals the previous cycle's value and is ≤15.
  - The counter clears on key_valid=0, a value change, or an illegal value.
  - When the count reaches DEBOUNCE and held=0: a one-cycle key_evt pulses with code = key_value, and held is set.
  - held clears only after DEBOUNCE consecutive cycles with key_valid=0. Result: exactly one event per physical press.
  - A different key pressed without release produces no event while held=1.
- Latency:
  - key_evt asserts DEBOUNCE cycles after the first stable sample.
  - State and register updates occur on the clock edge at which key_evt=1; they are visible the following cycle.
- Digit accumulate: acc <= acc*10 + d, cnt <= cnt+1, only if cnt < MAX_DIGITS. Otherwise the digit is ignored with no wrap.
- State S_A (0):
  - Digit: accumulate into op_a.
  - A-D: if cnt_a>0, latch opcode, clear op_b and cnt_b, go to S_B. Otherwise ignore.
  - E: clear everything, stay in S_A.
  - F: ignored.
- State S_B (1):
  - Digit: accumulate into op_b.
  - A-D: overwrite opcode, stay in S_B.
  - F: if cnt_b>0, go to S_REQ. Otherwise ignore.
  - E: clear everything, go to S_A.
- State S_REQ (2):
  - calc_req=1 from the cycle after entry.
  - op_a, op_b and opcode are held stable.
  - All key events, including E, are ignored.
  - On calc_ack=1: go to S_RES; calc_req deasserts the next cycle.
  - calc_ack=1 outside S_REQ is ignored.
  - No timeout; only rst_n aborts.
- State S_RES (3):
  - result_show=1.
  - Digit d: op_a<=d, cnt_a<=1, op_b<=0, result_show<=0, go to S_A.
  - E: clear everything, go to S_A.
  - A-D and F: ignored.
- disp_value: op_a in S_A, op_b in S_B and S_REQ, 0 in S_RES.
- Simultaneous events:
  - key_evt in the same cycle as calc_ack is impossible to act on, because keys are ignored in S_REQ.
  - Reset during S_REQ drops calc_req immediately (asynchronous).

Test Plan:
- Reset, then keys 1,2,A,3,F with DEBOUNCE=8 and clean presses/releases:
  - op_a=12, op_b=3, opcode=0.
  - calc_req rises; hold ack low for 20 cycles and calc_req stays 1.
  - Ack for 1 cycle: calc_req=0 the next cycle and result_show=1.
- Bounce: key_valid toggles every 3 cycles for 30 cycles then holds '5' for 8 cycles -> exactly one event; op_a=5.
- Overflow and ignore:
  - Keys 9,9,9,9,9 -> op_a=9999, cnt saturates.
  - F in S_A -> ignored.
  - A with no digits after reset -> stays in S_A.
- Operator overwrite and clear:
  - 7,A,C,4,F -> opcode=2, op_b=4.
  - In S_B, E -> all zero, S_A, disp_value=0.
- Result restart: in S_RES press 8 -> S_A, op_a=8, op_b=0, result_show=0; C and F pressed in S_RES before that are ignored.
- Async reset mid-S_REQ: assert rst_n=0 between edges -> calc_req=0 immediately and state_dbg=0; held key after reset needs a full DEBOUNCE to produce an event.
